// File: rtl/pcm_rom_fetch.sv
// pcm_rom_fetch: serves PCM ROM byte reads from a tagged 64-bit DDRAM line buffer.
// Defining PCM_PREFETCH_EN adds a next-line prefetch slot (states PFETCH, PWAIT).
//
// state  | meaning
// IDLE   | waiting for req; buffer hit check
// FETCH  | demand line read outstanding on DDRAM channel
// RESP   | data_rdy cycle, returns the addressed byte (or err)
// PFETCH | background read of the next line (prefetch build only)
// PWAIT  | requester stalled behind an in-flight prefetch (prefetch build only)
module pcm_rom_fetch #(
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              data_rdy,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] ch_addr,
    output logic              ch_req,
    input  logic              ch_ready,
    input  logic [63:0]       ch_dout
);
    localparam int TAG_W = ADDR_W - 3;
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef PCM_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, FETCH, RESP, PFETCH, PWAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
`endif

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [63:0]       line_q, line_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;
    logic              ch_req_q, ch_req_d;
    logic [ADDR_W-1:0] ch_addr_q, ch_addr_d;

    logic              main_hit, to_hit, fill_ok;
    logic [7:0]        resp_byte;
    logic [TAG_W-1:0]  ch_tag;

`ifdef PCM_PREFETCH_EN
    logic [63:0]       pline_q, pline_d;
    logic [TAG_W-1:0]  ptag_q, ptag_d;
    logic              pvalid_q, pvalid_d;
    logic              pf_go_q, pf_go_d;
    logic [TAG_W-1:0]  wtag_q, wtag_d;
    logic              pref_hit, same, waiting;
    logic [TAG_W-1:0]  dem_tag;

    assign pref_hit = pvalid_q && !flush && (ptag_q == addr[ADDR_W-1:3]);
`endif

    assign ch_tag    = ch_addr_q[ADDR_W-1:3];
    assign main_hit  = valid_q && !flush && (tag_q == addr[ADDR_W-1:3]);
    // A flush seen at any point of the fetch, including the fill cycle, keeps the line invalid.
    assign fill_ok   = !(flushed_q || flush);
    assign to_hit    = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC));
    assign resp_byte = err_q ? 8'h00 : line_q[{sel_q, 3'b000} +: 8];

    assign data_rdy  = (state_q == RESP);
    assign err       = data_rdy && err_q;
    assign data      = data_rdy ? resp_byte : data_q;
    assign ch_req    = ch_req_q;
    assign ch_addr   = ch_addr_q;
`ifdef PCM_PREFETCH_EN
    assign busy      = (state_q == FETCH) || (state_q == RESP) || (state_q == PWAIT);
`else
    assign busy      = (state_q == FETCH) || (state_q == RESP);
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        flushed_d = flushed_q | flush;
        ch_req_d  = ch_req_q;
        ch_addr_d = ch_addr_q;
`ifdef PCM_PREFETCH_EN
        pline_d   = pline_q;
        ptag_d    = ptag_q;
        pvalid_d  = pvalid_q;
        pf_go_d   = pf_go_q;
        wtag_d    = wtag_q;
        waiting   = 1'b0;
        dem_tag   = wtag_q;
        same      = 1'b0;
`endif
        case (state_q)
            IDLE: if (req) begin
                sel_d = addr[2:0];
                err_d = 1'b0;
                if (main_hit) begin
                    state_d = RESP;
                end
`ifdef PCM_PREFETCH_EN
                else if (pref_hit) begin
                    line_d   = pline_q;
                    tag_d    = ptag_q;
                    valid_d  = 1'b1;
                    pvalid_d = 1'b0;
                    pf_go_d  = 1'b1;
                    state_d  = RESP;
                end
`endif
                else begin
                    state_d   = FETCH;
                    ch_req_d  = 1'b1;
                    ch_addr_d = {addr[ADDR_W-1:3], 3'b000};
                    cnt_d     = CNT_W'(1);
                    flushed_d = 1'b0;
                end
            end
            FETCH: begin
                // ch_ready in the timeout cycle takes priority: a normal fill, no err.
                if (ch_ready) begin
                    line_d   = ch_dout;
                    tag_d    = ch_tag;
                    valid_d  = fill_ok;
                    ch_req_d = 1'b0;
                    state_d  = RESP;
`ifdef PCM_PREFETCH_EN
                    pf_go_d  = fill_ok;
`endif
                end else if (to_hit) begin
                    ch_req_d = 1'b0;
                    valid_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                data_d  = resp_byte;
                err_d   = 1'b0;
                state_d = IDLE;
`ifdef PCM_PREFETCH_EN
                pf_go_d = 1'b0;
                if (pf_go_q && !flush) begin
                    state_d   = PFETCH;
                    ch_req_d  = 1'b1;
                    ch_addr_d = {tag_q + TAG_W'(1), 3'b000};
                    cnt_d     = CNT_W'(1);
                    flushed_d = 1'b0;
                    pvalid_d  = 1'b0;
                end
`endif
            end
`ifdef PCM_PREFETCH_EN
            PFETCH, PWAIT: begin
                waiting = (state_q == PWAIT) || req;
                dem_tag = (state_q == PWAIT) ? wtag_q : addr[ADDR_W-1:3];
                same    = (dem_tag == ch_tag);
                if (state_q == PFETCH && req) begin
                    sel_d   = addr[2:0];
                    err_d   = 1'b0;
                    wtag_d  = dem_tag;
                    state_d = PWAIT;
                end
                if (ch_ready || to_hit) begin
                    ch_req_d = 1'b0;
                    if (!waiting) begin
                        state_d = IDLE;
                        if (ch_ready) begin
                            pline_d  = ch_dout;
                            ptag_d   = ch_tag;
                            pvalid_d = fill_ok;
                        end
                    end else if (same) begin
                        state_d = RESP;
                        if (ch_ready) begin
                            line_d  = ch_dout;
                            tag_d   = ch_tag;
                            valid_d = fill_ok;
                            pf_go_d = fill_ok;
                        end else begin
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                        end
                    end else begin
                        // Prefetch for another line is discarded; start the demand read.
                        state_d   = FETCH;
                        ch_req_d  = 1'b1;
                        ch_addr_d = {dem_tag, 3'b000};
                        cnt_d     = CNT_W'(1);
                        flushed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (flush) begin
            valid_d = 1'b0;
`ifdef PCM_PREFETCH_EN
            pvalid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
            ch_req_q  <= 1'b0;
            ch_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            flushed_q <= flushed_d;
            ch_req_q  <= ch_req_d;
            ch_addr_q <= ch_addr_d;
        end
    end

`ifdef PCM_PREFETCH_EN
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pline_q  <= '0;
            ptag_q   <= '0;
            pvalid_q <= 1'b0;
            pf_go_q  <= 1'b0;
            wtag_q   <= '0;
        end else begin
            pline_q  <= pline_d;
            ptag_q   <= ptag_d;
            pvalid_q <= pvalid_d;
            pf_go_q  <= pf_go_d;
            wtag_q   <= wtag_d;
        end
    end
`endif

endmodule

// File: doc/pcm_rom_fetch.md
Name: pcm_rom_fetch

Overview:
- Sits between the vball core's PCM ROM byte port and DDRAM read channel 1.
- Turns byte requests into 64-bit DDRAM line reads, holds the last line in a tagged buffer, and returns the addressed byte.
- Sequential PCM playback hits the buffer on 7 of every 8 bytes, which cuts DDRAM traffic by about 8x.
- Also handles flush during ROM download and a DDRAM timeout.

Parameters:
- ADDR_W, 18, byte address width of the PCM ROM space.
- TIMEOUT_CYC, 255, maximum clk_sys cycles to wait for ch_ready; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock (96 MHz).
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk_sys.
- flush  in  1  invalidates buffered lines; held high while ioctl_download is active.
- req  in  1  single-cycle byte read strobe from the core.
- addr  in  ADDR_W  byte address; sampled only when req=1.
- data  out  8  returned byte; held until the next data_rdy.
- data_rdy  out  1  one-cycle pulse when data is valid.
- busy  out  1  high from an accepted req until data_rdy.
- err  out  1  one-cycle pulse, coincident with data_rdy, on timeout.
- ch_addr  out  ADDR_W  DDRAM byte address with [2:0]=0; stable while ch_req=1.
- ch_req  out  1  level request; held until ch_ready.
- ch_ready  in  1  one-cycle pulse: ch_dout is valid.
- ch_dout  in  64  line data; byte n is [8n+7:8n].

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - data=0, data_rdy=0, busy=0, err=0, ch_req=0, ch_addr=0.
  - valid=0; state=IDLE; timeout counter cleared.
  - Reset mid-fetch drops ch_req immediately. A ch_ready arriving later in IDLE is ignored.
- Line buffer: 64-bit line, tag = addr[ADDR_W-1:3], valid bit.
- States: IDLE, FETCH, RESP.
- IDLE, req=1:
  - Capture addr.
  - Hit (valid and tag match): go to RESP. data_rdy pulses the next cycle, so hit latency is 1 cycle.
  - Miss: go to FETCH. ch_req=1 and ch_addr={addr[ADDR_W-1:3],3'b0} from the next cycle.
- FETCH:
  - Hold ch_req and ch_addr; increment the counter each cycle.
  - On ch_ready: store ch_dout, update tag, set valid=1 unless a flush occurred during this fetch. Drop ch_req the same cycle; go to RESP.
  - Miss latency is 1 cycle plus DDRAM latency plus 1 cycle from req to data_rdy.
- RESP:
  - data = line byte selected by captured addr[2:0]; data_rdy=1 for one cycle; busy=0 from the next cycle.
  - Return to IDLE.
- Timeout: counter reaches TIMEOUT_CYC in FETCH without ch_ready.
  - Drop ch_req; valid=0.
  - Next cycle: data=8'h00, data_rdy=1, err=1.
- req while busy=1: ignored; no queueing. The core waits for data_rdy.
- req and flush in the same cycle: flush wins for valid, so the req is treated as a miss.
- flush at any time clears valid the next cycle. During FETCH the line is still delivered to the requester but not marked valid.
- ch_ready arriving in the same cycle as the timeout: ch_ready wins; normal fill, no err.

Optional Feature:
- Macro: PCM_PREFETCH_EN.
- Defined:
  - Adds a second line buffer (prefetch slot) and states PFETCH and PWAIT.
  - After every demand fill or prefetch-slot hit on line L, issue a background fetch of line L+1, modulo 2^(ADDR_W-3), so the top line wraps to 0.
  - req hitting the prefetch slot: promote it to the main line, data_rdy after 1 cycle, then launch the prefetch of the next line.
  - req during an in-flight prefetch:
    - Same line: wait for ch_ready, then respond.
    - Different line: let the prefetch complete, discard it, then issue the demand fetch.
  - flush invalidates both slots.
- Undefined: single-line behaviour exactly as above; the prefetch logic is absent.

Test Plan:
- Reset, then req addr=0x00005; ch_ready with ch_dout=0x0807060504030201 three cycles after ch_req -> ch_addr=0x00000, data=0x06, data_rdy pulses once, busy drops.
- Follow-up req addr=0x00007 -> no ch_req; data=0x08 one cycle after req.
- req addr=0x00008 (next line) -> new ch_req with ch_addr=0x00008; then flush and re-request addr=0x00008 -> fresh ch_req issued.
- ch_ready never asserted with TIMEOUT_CYC=4 -> ch_req drops after 4 cycles; data=0x00 with data_rdy=1 and err=1; retry of the same address refetches.
- reset_n=0 while ch_req=1, then ch_ready pulses in IDLE -> all outputs 0; no data_rdy; valid stays 0.
- With PCM_PREFETCH_EN, req 0x3FFF8 -> fill, then prefetch ch_addr=0x00000; req 0x00003 after the prefetch lands -> data_rdy 1 cycle later with no new ch_req.
